// File: rtl/chnl_stream_arb_pkg.sv
// Shared types and constants for the channel stream arbiter.
// Holds the FSM state encoding and the ceil-log2 helper used to size the source tag.
package chnl_stream_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/chnl_stream_arb_rr_pick.sv
// Rotating-priority encoder: picks the first set request after the last grant, wrapping.
// Purely combinational; any=0 means no request is pending.
module chnl_stream_arb_rr_pick
   import chnl_stream_arb_pkg::*;
#(
   parameter  int N   = 4,
   localparam int IDW = clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] last,
   output logic [N-1:0]   gnt_onehot,
   output logic [IDW-1:0] gnt_idx,
   output logic           any
);

   logic [IDW-1:0] idx;

   // Walk the ports starting one past the last winner; the first hit wins.
   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      any        = 1'b0;
      idx        = '0;
      for (int k = 1; k <= N; k++) begin
         idx = IDW'((int'(last) + k) % N);
         if (!any && req[idx]) begin
            any             = 1'b1;
            gnt_onehot[idx] = 1'b1;
            gnt_idx         = idx;
         end
      end
   end

endmodule

// File: rtl/chnl_stream_arb.sv
// Packet-aware N-way round-robin arbiter feeding one registered valid/ready output.
// A winner keeps the grant until its last beat transfers; every beat carries its source index.
module chnl_stream_arb
   import chnl_stream_arb_pkg::*;
#(
   parameter  int N     = 4,
   parameter  int WIDTH = 32,
   localparam int IDW   = clog2(N)
) (
   input  logic               clk,
   input  logic               srst,
   input  logic [N-1:0]       s_val,
   output logic [N-1:0]       s_rdy,
   input  logic [N*WIDTH-1:0] s_data,
   input  logic [N-1:0]       s_last,
   output logic               m_val,
   input  logic               m_rdy,
   output logic [WIDTH-1:0]   m_data,
   output logic               m_last,
   output logic [IDW-1:0]     m_src,
   output logic               busy
);

   state_t         state;
   logic [IDW-1:0] last_grant;
   logic [IDW-1:0] owner;
   logic [IDW-1:0] sel;
   logic [N-1:0]   gnt_onehot;
   logic [IDW-1:0] gnt_idx;
   logic           any;
   logic           space;
   logic           take;

   chnl_stream_arb_rr_pick #(.N(N)) u_pick (
      .req        (s_val),
      .last       (last_grant),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx),
      .any        (any)
   );

   // Ready depends only on valids, downstream ready and state, never on data or last.
   always_comb begin
      space = ~m_val | m_rdy;
      s_rdy = '0;
      sel   = gnt_idx;
      if (!srst) begin
         if (state == LOCKED) begin
            sel          = owner;
            s_rdy[owner] = space;
         end else if (any && space) begin
            s_rdy = gnt_onehot;
         end
      end
      take = s_val[sel] & s_rdy[sel];
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         m_val      <= 1'b0;
         m_data     <= '0;
         m_last     <= 1'b0;
         m_src      <= '0;
         state      <= IDLE;
         last_grant <= IDW'(N - 1);
         owner      <= '0;
         busy       <= 1'b0;
      end else begin
         if (take) begin
            m_val  <= 1'b1;
            m_data <= s_data[sel*WIDTH +: WIDTH];
            m_last <= s_last[sel];
            m_src  <= sel;
         end else if (m_rdy) begin
            m_val <= 1'b0;
         end
         // A last beat releases the lock and advances rotation; any other beat (re)asserts it.
         if (take) begin
            if (s_last[sel]) begin
               state      <= IDLE;
               busy       <= 1'b0;
               last_grant <= sel;
            end else begin
               state <= LOCKED;
               busy  <= 1'b1;
               owner <= sel;
            end
         end
      end
   end

endmodule

// File: doc/chnl_stream_arb.md
Name: chnl_stream_arb

Overview:
- N-way round-robin arbiter that merges N independent valid/ready requester streams into the single write port of one channel FIFO (i_val/i_rdy/i_data side).
- Packet-aware: once a requester wins, the grant stays locked to it until its beat flagged last has transferred, so packets never interleave in the FIFO.
- Each beat is tagged with its source index.
- Output is registered: one register stage between the requesters and the FIFO.

Parameters:
- N, 4, number of requester ports; legal range 2..16.
- WIDTH, 32, data bits per beat.
- IDW, derived localparam = ceil(log2(N)), width of source tag.

Ports:
- clk  in  1  clock.
- srst  in  1  reset, synchronous, active-high.
- s_val  in  N  per-requester beat valid.
- s_rdy  out  N  per-requester beat accepted; a transfer on port i happens when s_val[i] && s_rdy[i].
- s_data  in  N*WIDTH  requester data; port i occupies bits [i*WIDTH +: WIDTH].
- s_last  in  N  per-requester last-beat-of-packet flag.
- m_val  out  1  output beat valid (drives FIFO i_val).
- m_rdy  in  1  downstream ready (FIFO i_rdy).
- m_data  out  WIDTH  output beat data.
- m_last  out  1  output last flag.
- m_src  out  IDW  index of the requester that produced the output beat.
- busy  out  1  high while a multi-beat packet holds the lock.

Behaviour:
- Reset, while srst is high and on the cycle after:
  - m_val=0, m_data/m_last/m_src=0, s_rdy=all 0, busy=0.
  - state=IDLE, last_grant=N-1, so port 0 has first priority.
- space = ~m_val | m_rdy. The output register can take a beat this cycle.
- Output register:
  - On an accepted source beat: load m_data/m_last/m_src and set m_val=1.
  - Else if m_rdy: clear m_val.
  - Else: hold all outputs. m_val, once set, never drops without m_rdy.
  - Throughput: 1 beat/cycle when m_rdy stays high.
- Latency: source beat accepted in cycle t appears on m_* in cycle t+1.
- State IDLE:
  - winner = first i with s_val[i]=1, searching from (last_grant+1) mod N upward, wrapping.
  - If any s_val and space: s_rdy[winner]=1, all other s_rdy=0, and the beat transfers this cycle.
  - If the transferred beat has s_last=1: stay IDLE, last_grant<=winner.
  - Else: go to LOCKED with owner<=winner, busy=1.
  - If no s_val or no space: s_rdy=0 and last_grant is unchanged.
- State LOCKED:
  - s_rdy[owner]=space; all other s_rdy=0.
  - Other requesters' s_val are ignored regardless of level.
  - A beat with s_last=0 transfers and the state stays LOCKED.
  - A beat with s_last=1 transfers, the state goes to IDLE, last_grant<=owner, and busy goes to 0 the next cycle.
  - owner dropping s_val mid-packet: lock is held indefinitely, no timeout.
- s_rdy is combinational from s_val, m_rdy and state. There is no combinational path from s_data/s_last to s_rdy.
- Boundary conditions:
  - Requesters sampled simultaneously are served in rotation order from last_grant+1. With N=4 and all asserting after reset, single-beat packets are granted 0,1,2,3,0,...
  - A requester that drops s_val before winning loses nothing; it is re-evaluated each cycle.
  - A single requester winning back-to-back is allowed when it is the only requester with s_val set.
  - srst mid-packet:
    - Discards the output register contents and the lock.
    - The requester is responsible for restarting its packet.
    - No beats are emitted during srst.
  - m_rdy low for many cycles: all s_rdy=0 while m_val=1 and m_rdy=0. No beat is lost or duplicated.

Decomposition:
- Shared package/include holds:
  - The ceil-log2 constant function used for IDW.
  - State encodings: IDLE=0, LOCKED=1.
- One natural sub-module: rr_pick.
  - Combinational rotating-priority encoder.
  - Inputs: req[N], last[IDW].
  - Outputs: gnt_onehot[N], gnt_idx[IDW], any.
  - Instantiated once.

Test Plan:
- Reset then idle: hold srst 3 cycles with all s_val=1 -> s_rdy=0 and m_val=0 throughout. First grant after release goes to port 0; m_src=0 one cycle later.
- Fair rotation: N=4, all ports stream single-beat packets (s_last=1) with data 0xA0+i, m_rdy=1 -> m_src sequence 0,1,2,3,0,1... at one beat per cycle, each port receiving exactly 1/4 of beats.
- Packet lock: port 2 sends a 5-beat packet (last on beat 5) while ports 0,1,3 all assert s_val -> 5 consecutive m_src=2 beats, m_last only on the 5th. Next grant goes to 3, then 0.
- Backpressure: m_rdy toggles 1,0,0,1,... during a 4-beat packet from port 1 -> no s_rdy while m_val=1 and m_rdy=0. Output is exactly 4 beats in order, data unchanged while stalled.
- Mid-packet reset: port 0 sends 2 of 6 beats, then srst for 1 cycle -> m_val=0 and busy=0 after reset. A new request from port 3 is granted immediately, without waiting for port 0's last.
- Lock hold with gap: port 1 drops s_val for 3 cycles mid-packet while port 2 requests -> port 2 never receives s_rdy until port 1's last beat transfers. Port 2 is granted on the next cycle after that.
